// File: rtl/riscv_pl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pl_pkg
// Shared types and constants for the pipelined RV32I fetch path.
//   XLEN        datapath width
//   NOP_INST    canonical NOP (addi x0, x0, 0) shown to decode when idle
//   fq_state_t  fetch-queue control states
//   fq_entry_t  one buffered fetch: {pc, inst}
// ---------------------------------------------------------------------------
package riscv_pl_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } fq_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fq_entry_t;

    // Next sequential word address; wraps naturally at 2^32.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage : riscv_pl_pkg

// File: rtl/if_fetch_queue_fifo.sv
// ---------------------------------------------------------------------------
// fq_fifo
// Synchronous DEPTH x fq_entry_t FIFO used as the fetch buffer.
//   clk, rst     clock, synchronous active-high reset
//   push         write push_data at the tail
//   pop          drop the head entry
//   clear        synchronous flush of all entries (wins over push/pop)
//   push_data    entry to write
//   head         current head entry (meaningful when count != 0)
//   count        number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap without compare logic.
// ---------------------------------------------------------------------------
module fq_fifo
    import riscv_pl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  fq_entry_t     push_data,
    output fq_entry_t     head,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    fq_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; occupancy alone qualifies the contents.
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !clear && (count == CW'(DEPTH))));

    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(pop && !clear && (count == '0)));

endmodule : fq_fifo

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// Fetch stage between a fixed 1-cycle-latency instruction memory and decode.
// Generates sequential fetch PCs, reserves buffer space at request time,
// buffers returned words and hands {pc, inst} to decode over valid/ready.
// A redirect (fq_flush) restarts fetch at fq_flush_pc and drops stale words.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   fq_imem_req   imem read request this cycle
//   fq_imem_addr  imem byte address of the request (held when idle)
//   fq_imem_inst  imem read data, one cycle after the request
//   fq_flush      redirect from execute
//   fq_flush_pc   redirect target (word aligned)
//   fq_valid      fq_inst/fq_pc carry a valid instruction
//   fq_ready      decode accepts the word this cycle
//   fq_inst       instruction to decode (NOP when idle)
//   fq_pc         PC of fq_inst (0 when idle)
//
// Configuration
//   FQ_BYPASS_EN  when defined, a response arriving at an empty buffer is
//                 forwarded to decode in the same cycle (and not stored if
//                 taken). When undefined, every word passes through the
//                 buffer and the decode outputs come straight from flops.
// ---------------------------------------------------------------------------
module if_fetch_queue
    import riscv_pl_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            fq_imem_req,
    output logic [XLEN-1:0] fq_imem_addr,
    input  logic [XLEN-1:0] fq_imem_inst,
    input  logic            fq_flush,
    input  logic [XLEN-1:0] fq_flush_pc,
    output logic            fq_valid,
    input  logic            fq_ready,
    output logic [XLEN-1:0] fq_inst,
    output logic [XLEN-1:0] fq_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

    fq_state_t       state_q;
    fq_state_t       state_nxt;

    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            pending_q;
    logic            discard_q;

    logic [CW-1:0]   count;
    fq_entry_t       head;
    fq_entry_t       resp_entry;

    logic [CW:0]     inflight;
    logic            fifo_empty;
    logic            resp_ok;
    logic            bypass;
    logic            fifo_push;
    logic            fifo_pop;
    logic            pop_any;
    logic            issue;

    // Words already held plus the one on its way back; space is reserved at issue.
    assign inflight   = {1'b0, count} + (CW + 1)'(pending_q);
    assign fifo_empty = (count == '0);
    assign resp_ok    = pending_q && !discard_q;

`ifdef FQ_BYPASS_EN
    assign bypass = resp_ok && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    // Decode-side view: buffer head first, else the forwarded response, else NOP.
    assign fq_valid = !fifo_empty || bypass;
    assign fq_inst  = !fifo_empty ? head.inst :
                      bypass      ? fq_imem_inst : NOP_INST;
    assign fq_pc    = !fifo_empty ? head.pc :
                      bypass      ? req_pc_q : '0;

    // A redirect overrides any handshake in the same cycle.
    assign pop_any   = fq_valid && fq_ready && !fq_flush;
    assign fifo_pop  = !fifo_empty && fq_ready && !fq_flush;
    assign fifo_push = resp_ok && !fq_flush && !(bypass && fq_ready);

    assign resp_entry = '{pc: req_pc_q, inst: fq_imem_inst};

    fq_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .clear     (fq_flush),
        .push_data (resp_entry),
        .head      (head),
        .count     (count)
    );

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM: next state. A redirect is taken from any state.
    always_comb begin
        state_nxt = state_q;
        if (fq_flush) begin
            state_nxt = FLUSH;
        end else begin
            case (state_q)
                RUN:     if ((inflight == FULL) && !pop_any) state_nxt = STALL;
                STALL:   if (pop_any) state_nxt = RUN;
                FLUSH:   state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    // FSM: outputs. The cycle after a redirect fetches the target at once,
    // so FLUSH issues exactly like RUN (the buffer is empty by then).
    always_comb begin
        issue = 1'b0;
        if (!rst && !fq_flush && (state_q != STALL) && (inflight < FULL)) begin
            issue = 1'b1;
        end
    end

    assign fq_imem_req  = issue;
    assign fq_imem_addr = fetch_pc_q;

    // Fetch PC, in-flight tracking and stale-response suppression.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            pending_q  <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            pending_q <= issue;
            discard_q <= fq_flush && pending_q;
            if (fq_flush) begin
                fetch_pc_q <= fq_flush_pc;
            end else if (issue) begin
                fetch_pc_q <= pc_next(fetch_pc_q);
                req_pc_q   <= fetch_pc_q;
            end
        end
    end

    a_addr_aligned : assert property (@(posedge clk) disable iff (rst)
        fq_imem_req |-> (fq_imem_addr[1:0] == 2'b00));

    a_flush_aligned : assert property (@(posedge clk) disable iff (rst)
        fq_flush |-> (fq_flush_pc[1:0] == 2'b00));

endmodule : if_fetch_queue

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fq_imem_req;
    logic [31:0] fq_imem_addr;
    logic [31:0] fq_imem_inst;
    logic        fq_flush = 1'b0;
    logic [31:0] fq_flush_pc = 32'h0;
    logic        fq_valid;
    logic        fq_ready = 1'b0;
    logic [31:0] fq_inst;
    logic [31:0] fq_pc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] iss_q[$];
    int          iss_cyc[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_inst[$];
    int          del_cyc[$];

    if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .fq_imem_req  (fq_imem_req),
        .fq_imem_addr (fq_imem_addr),
        .fq_imem_inst (fq_imem_inst),
        .fq_flush     (fq_flush),
        .fq_flush_pc  (fq_flush_pc),
        .fq_valid     (fq_valid),
        .fq_ready     (fq_ready),
        .fq_inst      (fq_inst),
        .fq_pc        (fq_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // 1-cycle imem model
    always @(posedge clk) begin
        cyc <= cyc + 1;
        fq_imem_inst <= fq_imem_req ? inst_of(fq_imem_addr) : 32'hDEAD_BEEF;
    end

    // Mid-cycle log of issued requests and accepted instructions
    always @(negedge clk) begin
        if (!rst && fq_imem_req) begin
            iss_q.push_back(fq_imem_addr);
            iss_cyc.push_back(cyc);
        end
        if (!rst && fq_valid && fq_ready && !fq_flush) begin
            del_pc.push_back(fq_pc);
            del_inst.push_back(fq_inst);
            del_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        iss_q.delete(); iss_cyc.delete();
        del_pc.delete(); del_inst.delete(); del_cyc.delete();
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1; fq_flush = 1'b0; fq_ready = rdy;
        tick(2);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        rst = 1'b1; fq_flush = 1'b0; fq_ready = 1'b1;
        tick(2);
        total++; if (fq_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", fq_valid); end
        total++; if (fq_imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", fq_imem_req); end
        total++; if (fq_inst !== NOP) begin bad++; $display("FAIL reset_inst: got %h want %h", fq_inst, NOP); end
        total++; if (fq_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", fq_pc); end
        total++; if (fq_imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", fq_imem_addr); end
    endtask

    task automatic test_free_run();
        do_reset(1'b1);
        tick(20);
        total++;
        if (iss_q.size() < 10 || del_pc.size() < 10) begin
            bad++; $display("FAIL free_run_len: got iss=%0d del=%0d want >=10", iss_q.size(), del_pc.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                total++; if (iss_q[i] !== 32'(4 * i)) begin bad++; $display("FAIL free_run_req[%0d]: got %h want %h", i, iss_q[i], 32'(4 * i)); end
                total++; if (del_pc[i] !== 32'(4 * i)) begin bad++; $display("FAIL free_run_pc[%0d]: got %h want %h", i, del_pc[i], 32'(4 * i)); end
                total++; if (del_inst[i] !== inst_of(32'(4 * i))) begin bad++; $display("FAIL free_run_inst[%0d]: got %h want %h", i, del_inst[i], inst_of(32'(4 * i))); end
            end
            total++; if (del_cyc[0] - iss_cyc[0] != LAT) begin bad++; $display("FAIL free_run_latency: got %0d want %0d", del_cyc[0] - iss_cyc[0], LAT); end
            total++; if (del_cyc[9] - del_cyc[0] != 9) begin bad++; $display("FAIL free_run_rate: got %0d want 9", del_cyc[9] - del_cyc[0]); end
        end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        tick(10);
        total++; if (iss_q.size() != 4) begin bad++; $display("FAIL stall_issued: got %0d want 4", iss_q.size()); end
        for (int i = 0; i < 4 && i < iss_q.size(); i++) begin
            total++; if (iss_q[i] !== 32'(4 * i)) begin bad++; $display("FAIL stall_req[%0d]: got %h want %h", i, iss_q[i], 32'(4 * i)); end
        end
        total++; if (del_pc.size() != 0) begin bad++; $display("FAIL stall_nodeliver: got %0d want 0", del_pc.size()); end
        total++; if (fq_imem_req !== 1'b0) begin bad++; $display("FAIL stall_req_low: got %b want 0", fq_imem_req); end
        total++; if (fq_valid !== 1'b1 || fq_pc !== 32'h0) begin bad++; $display("FAIL stall_head: got v=%b pc=%h want v=1 pc=0", fq_valid, fq_pc); end
        fq_ready = 1'b1;
        tick(12);
        total++;
        if (del_pc.size() < 8 || iss_q.size() < 5) begin
            bad++; $display("FAIL stall_release_len: got del=%0d iss=%0d want >=8,>=5", del_pc.size(), iss_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++; if (del_pc[i] !== 32'(4 * i)) begin bad++; $display("FAIL stall_order[%0d]: got %h want %h", i, del_pc[i], 32'(4 * i)); end
            end
            total++; if (iss_q[4] !== 32'h10) begin bad++; $display("FAIL stall_resume: got %h want 00000010", iss_q[4]); end
        end
    endtask

    task automatic test_flush_pending();
        int f;
        int n;
        do_reset(1'b1);
        tick(5);
        total++; if (iss_cyc.size() == 0 || iss_cyc[iss_cyc.size() - 1] != cyc - 1) begin bad++; $display("FAIL flushp_pending: no request in previous cycle"); end
        n = del_pc.size();
        fq_flush = 1'b1; fq_flush_pc = 32'h100; f = cyc;
        #1;
        total++; if (fq_imem_req !== 1'b0) begin bad++; $display("FAIL flushp_req_in_flush: got %b want 0", fq_imem_req); end
        tick(1);
        fq_flush = 1'b0;
        #1;
        total++; if (fq_imem_req !== 1'b1 || fq_imem_addr !== 32'h100) begin bad++; $display("FAIL flushp_first_req: got req=%b addr=%h want 1 00000100", fq_imem_req, fq_imem_addr); end
        total++; if (fq_valid !== 1'b0) begin bad++; $display("FAIL flushp_valid_after: got %b want 0", fq_valid); end
        tick(6);
        total++;
        if (del_pc.size() < n + 2) begin
            bad++; $display("FAIL flushp_len: got %0d want >=%0d", del_pc.size(), n + 2);
        end else begin
            total++; if (del_pc[n] !== 32'h100) begin bad++; $display("FAIL flushp_pc0: got %h want 00000100", del_pc[n]); end
            total++; if (del_pc[n + 1] !== 32'h104) begin bad++; $display("FAIL flushp_pc1: got %h want 00000104", del_pc[n + 1]); end
            total++; if (del_inst[n] !== inst_of(32'h100)) begin bad++; $display("FAIL flushp_inst0: got %h want %h", del_inst[n], inst_of(32'h100)); end
            total++; if (del_cyc[n] - f != LAT + 1) begin bad++; $display("FAIL flushp_latency: got %0d want %0d", del_cyc[n] - f, LAT + 1); end
        end
    endtask

    task automatic test_flush_full();
        int f;
        do_reset(1'b0);
        tick(10);
        fq_ready = 1'b1; fq_flush = 1'b1; fq_flush_pc = 32'h200; f = cyc;
        #1;
        total++; if (fq_imem_req !== 1'b0) begin bad++; $display("FAIL flushf_req_in_flush: got %b want 0", fq_imem_req); end
        tick(1);
        fq_flush = 1'b0;
        #1;
        total++; if (fq_valid !== 1'b0) begin bad++; $display("FAIL flushf_valid_after: got %b want 0", fq_valid); end
        total++; if (del_pc.size() != 0) begin bad++; $display("FAIL flushf_delivered: got %0d want 0", del_pc.size()); end
        tick(6);
        total++;
        if (del_pc.size() < 2) begin
            bad++; $display("FAIL flushf_len: got %0d want >=2", del_pc.size());
        end else begin
            total++; if (del_pc[0] !== 32'h200) begin bad++; $display("FAIL flushf_pc0: got %h want 00000200", del_pc[0]); end
            total++; if (del_pc[1] !== 32'h204) begin bad++; $display("FAIL flushf_pc1: got %h want 00000204", del_pc[1]); end
            total++; if (del_cyc[0] - f != LAT + 1) begin bad++; $display("FAIL flushf_latency: got %0d want %0d", del_cyc[0] - f, LAT + 1); end
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        tick(3);
        fq_flush = 1'b1; fq_flush_pc = 32'hFFFF_FFFC;
        tick(1);
        fq_flush = 1'b0;
        clear_log();
        tick(6);
        total++;
        if (iss_q.size() < 3 || del_pc.size() < 2) begin
            bad++; $display("FAIL wrap_len: got iss=%0d del=%0d want >=3,>=2", iss_q.size(), del_pc.size());
        end else begin
            total++; if (iss_q[0] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req0: got %h want fffffffc", iss_q[0]); end
            total++; if (iss_q[1] !== 32'h0) begin bad++; $display("FAIL wrap_req1: got %h want 00000000", iss_q[1]); end
            total++; if (iss_q[2] !== 32'h4) begin bad++; $display("FAIL wrap_req2: got %h want 00000004", iss_q[2]); end
            total++; if (del_pc[0] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc0: got %h want fffffffc", del_pc[0]); end
            total++; if (del_pc[1] !== 32'h0 || del_inst[1] !== inst_of(32'h0)) begin bad++; $display("FAIL wrap_pc1: got %h/%h want 00000000/%h", del_pc[1], del_inst[1], inst_of(32'h0)); end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset(1'b0);
        tick(4);
        total++; if (fq_imem_req !== 1'b0 || fq_valid !== 1'b1 || fq_pc !== 32'h0) begin bad++; $display("FAIL rststall_pre: got req=%b v=%b pc=%h want 0 1 0", fq_imem_req, fq_valid, fq_pc); end
        rst = 1'b1;
        tick(1);
        total++; if (fq_valid !== 1'b0) begin bad++; $display("FAIL rststall_valid: got %b want 0", fq_valid); end
        total++; if (fq_imem_req !== 1'b0) begin bad++; $display("FAIL rststall_req: got %b want 0", fq_imem_req); end
        rst = 1'b0;
        #1;
        total++; if (fq_imem_req !== 1'b1 || fq_imem_addr !== 32'h0) begin bad++; $display("FAIL rststall_first_req: got req=%b addr=%h want 1 00000000", fq_imem_req, fq_imem_addr); end
        clear_log();
        fq_ready = 1'b1;
        tick(5);
        total++;
        if (del_pc.size() < 2) begin
            bad++; $display("FAIL rststall_len: got %0d want >=2", del_pc.size());
        end else begin
            total++; if (del_pc[0] !== 32'h0 || del_pc[1] !== 32'h4) begin bad++; $display("FAIL rststall_order: got %h,%h want 0,4", del_pc[0], del_pc[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_flush_pending();
        test_flush_full();
        test_wrap();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_if_fetch_queue
